heroe_ctrl: RTL and testbench
=============================

# heroe_ctrl

Control block that produces the `tipo_h`/`var_h` selection codes consumed by the hero seven-segment pattern ROM. It turns four push-buttons into two outputs:
- the selected hero type, cycling 0..4;
- a timed action variant: jump, fly, or crouch.

It sits between the board button inputs and the ROM, and owns all sequencing so the ROM stays purely combinational.

## Interface
Parameters:
- `TICK_DIV`, 5_000_000: clock cycles per action tick (≥2).
- `ACT_TICKS`, 5: jump duration in ticks (≥1).
- `FLY_TICKS`, 10: fly duration in ticks (≥1).
- `DB_CYCLES`, 16: debounce stability window in cycles; used only when `HEROE_DEBOUNCE_EN` is defined.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_tipo` in 1: advance hero type; asynchronous pin.
- `btn_saltar` in 1: jump request; asynchronous pin.
- `btn_volar` in 1: fly request; asynchronous pin.
- `btn_agachar` in 1: crouch, level-held; asynchronous pin.
- `tipo_h` out 3: hero type code 0..4, registered.
- `var_h` out 2: 0 idle, 1 jump, 2 fly, 3 crouch; registered.
- `busy` out 1: high whenever `var_h` != 0; registered.

## Operation
- **Input conditioning.** Each button passes through a 2-FF synchronizer. A rising edge is stage-2 high with the previous stage-2 value low.
- **FSM states:** IDLE (`var_h`=0), SALTO (1), VUELO (2), AGACHADO (3).
- **IDLE transitions.** Evaluated in priority order when several events occur in the same cycle:
  - `btn_saltar` edge → SALTO.
  - else `btn_volar` edge → VUELO.
  - else synchronized `btn_agachar` level high → AGACHADO.
  - else `btn_tipo` edge → `tipo_h` increments, wrapping 4→0; state stays IDLE.
- **SALTO / VUELO.** Entry clears the prescaler and the tick counter.
  - Prescaler counts 0..`TICK_DIV`-1; a tick fires at terminal count.
  - The state returns to IDLE on the tick that brings the tick count to `ACT_TICKS` (SALTO) or `FLY_TICKS` (VUELO).
- **AGACHADO.** Held while the synchronized `btn_agachar` level is high. Returns to IDLE the cycle after the level is seen low.
- **Inputs ignored outside IDLE.** All button edges outside IDLE are ignored and not queued, including `btn_tipo`. `tipo_h` never changes during an action.
- **Counter widths.** Prescaler and tick counter are sized with `$clog2` of their limits. Counters never wrap mid-action.
- **Outputs.** `busy` = (next `var_h` != 0), registered together with `var_h`.

## Timing
- **Reset values.** `tipo_h`=0, `var_h`=0, `busy`=0; synchronizers, edge registers and counters all 0.
- **Reset behaviour.** Assertion takes effect immediately (asynchronous), including mid-action. After release the FSM is in IDLE.
- **Button latency.** A button first sampled high at edge N updates `var_h`/`tipo_h` at edge N+2.
- **Action length.** Once `var_h` becomes 1 it holds for exactly `ACT_TICKS`×`TICK_DIV` cycles, then reads 0. Fly behaves the same with `FLY_TICKS`.
- **Crouch release.** `btn_agachar` first sampled low at edge M → `var_h`=0 at edge M+2.
- **Back-to-back actions.** A new action may be requested the cycle IDLE is re-entered. A button already held then produces no edge and does not retrigger.

## Configuration
- **`HEROE_DEBOUNCE_EN` defined.**
  - A debounce filter follows each synchronizer.
  - The filtered level changes only after stage-2 has held the new value for `DB_CYCLES` consecutive cycles.
  - Edge detection and the crouch level use the filtered signal.
  - All latencies above grow by `DB_CYCLES` cycles.
- **Undefined.** No filter is present; latencies are as stated above.

## Test plan
Test parameters: `TICK_DIV`=4, `ACT_TICKS`=3, `FLY_TICKS`=5, macro undefined.
- **Reset.** Assert `rst_n`=0 mid-flight → `tipo_h`=0, `var_h`=0, `busy`=0 immediately; after release `var_h` stays 0.
- **Type cycling.** Pulse `btn_tipo` six times in IDLE → `tipo_h` reads 1,2,3,4,0,1, each change 2 edges after sampling.
- **Jump and fly durations.**
  - `btn_saltar` pulse → `var_h`=1, `busy`=1 for exactly 12 cycles, then 0.
  - `btn_volar` pulse → `var_h`=2 for exactly 20 cycles.
- **Ignored inputs.** During a jump, pulse `btn_volar` and `btn_tipo` → `var_h` stays 1, `tipo_h` unchanged, and `var_h` returns to 0 with no later fly.
- **Simultaneous requests.** `btn_saltar` and `btn_volar` rise in the same cycle → `var_h`=1.
- **Crouch.** Hold `btn_agachar` 30 cycles → `var_h`=3 throughout the hold, returning to 0 two edges after release.

Source files
------------

// File: rtl/heroe_ctrl.sv
// heroe_ctrl: sequencing for the hero seven-segment pattern ROM.
// Turns four asynchronous push-buttons into a hero type code (tipo_h,
// cycling 0..4) and a timed action variant (var_h: idle/jump/fly/crouch).
// Optional feature macro: HEROE_DEBOUNCE_EN adds a DB_CYCLES-long
// stability filter after each synchronizer.
// The FSM state register drives var_h directly, so var_h is the state.
module heroe_ctrl #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int ACT_TICKS = 5,
  parameter int FLY_TICKS = 10,
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_tipo,
  input  logic       btn_saltar,
  input  logic       btn_volar,
  input  logic       btn_agachar,
  output logic [2:0] tipo_h,
  output logic [1:0] var_h,
  output logic       busy
);

  // Counter sizing: counters compare against limit-1, so $clog2 of the
  // limit is always wide enough and they never wrap mid-action.
  localparam int PW        = $clog2(TICK_DIV);
  localparam int MAX_TICKS = (ACT_TICKS > FLY_TICKS) ? ACT_TICKS : FLY_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ACT_LAST = TW'(ACT_TICKS - 1);
  localparam logic [TW-1:0] FLY_LAST = TW'(FLY_TICKS - 1);

  // Bit positions inside the packed button vectors.
  localparam int B_TIPO    = 0;
  localparam int B_SALTAR  = 1;
  localparam int B_VOLAR   = 2;
  localparam int B_AGACHAR = 3;

  // State encoding equals the var_h code so the state is visible on var_h.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SALTO    = 2'd1,
    VUELO    = 2'd2,
    AGACHADO = 2'd3
  } state_e;

  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    lvl;       // conditioned button levels
  logic [2:0]    prev_q;    // previous level of the edge-detected buttons
  logic [2:0]    rise;

  state_e        state_q;
  logic [2:0]    tipo_q;
  logic          busy_q;
  logic [PW-1:0] psc_q;
  logic [TW-1:0] tick_q;

  assign btn_raw = {btn_agachar, btn_volar, btn_saltar, btn_tipo};

  // Two-flop synchronizer on every button pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef HEROE_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [3:0]     filt_q;
  logic [DBW-1:0] db_cnt_q [4];

  // Debounce: the filtered level follows stage-2 only after it has held a
  // new value for DB_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // Previous-level register for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= lvl[2:0];
    end
  end

  assign rise = lvl[2:0] & ~prev_q;

  // Action FSM with prescaler/tick counters and registered outputs.
  // Counters are held at zero in IDLE, which clears them on action entry.
  // Button edges outside IDLE are dropped, never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tipo_q  <= '0;
      busy_q  <= 1'b0;
      psc_q   <= '0;
      tick_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          psc_q  <= '0;
          tick_q <= '0;
          if (rise[B_SALTAR]) begin
            state_q <= SALTO;
            busy_q  <= 1'b1;
          end else if (rise[B_VOLAR]) begin
            state_q <= VUELO;
            busy_q  <= 1'b1;
          end else if (lvl[B_AGACHAR]) begin
            state_q <= AGACHADO;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
            if (rise[B_TIPO]) begin
              tipo_q <= (tipo_q == 3'd4) ? 3'd0 : tipo_q + 3'd1;
            end
          end
        end
        SALTO, VUELO: begin
          if (psc_q == PSC_LAST) begin
            psc_q <= '0;
            if (tick_q == ((state_q == SALTO) ? ACT_LAST : FLY_LAST)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              tick_q  <= '0;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end else begin
            psc_q <= psc_q + 1'b1;
          end
        end
        AGACHADO: begin
          if (!lvl[B_AGACHAR]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tipo_h = tipo_q;
  assign var_h  = state_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_heroe_ctrl.sv
// Bench for heroe_ctrl with TICK_DIV=4, ACT_TICKS=3, FLY_TICKS=5.
// Each scenario queues per-cycle button stimulus together with the expected
// {busy, var_h, tipo_h} after that cycle's clock edge, then replays the
// stimulus and pops the expected queue as the DUT produces each output.
module tb_heroe_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_tipo;
  logic       btn_saltar;
  logic       btn_volar;
  logic       btn_agachar;
  logic [2:0] tipo_h;
  logic [1:0] var_h;
  logic       busy;

  // Button vector order: {agachar, volar, saltar, tipo}
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] TIPO = 4'b0001;
  localparam logic [3:0] SALT = 4'b0010;
  localparam logic [3:0] VOLA = 4'b0100;
  localparam logic [3:0] AGAC = 4'b1000;

  logic [5:0] exp_q[$];
  logic [3:0] stim_q[$];
  int         n_checks;
  int         n_fail;
  logic [2:0] exp_tipo;

  heroe_ctrl #(
    .TICK_DIV (4),
    .ACT_TICKS(3),
    .FLY_TICKS(5),
    .DB_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_tipo   (btn_tipo),
    .btn_saltar (btn_saltar),
    .btn_volar  (btn_volar),
    .btn_agachar(btn_agachar),
    .tipo_h     (tipo_h),
    .var_h      (var_h),
    .busy       (busy)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output word {busy, var_h, tipo_h}; busy follows var_h != 0.
  function automatic logic [5:0] pk(input logic [1:0] v, input logic [2:0] t);
    return {(v != 2'd0), v, t};
  endfunction

  // Driver: apply buttons, advance one clock edge, settle 1ns past it.
  task automatic drive(input logic [3:0] b);
    {btn_agachar, btn_volar, btn_saltar, btn_tipo} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [5:0] got;
    rst_n = 1'b0;
    {btn_agachar, btn_volar, btn_saltar, btn_tipo} = NONE;
    exp_tipo = 3'd0;
    #12;
    exp_q.push_back(pk(2'd0, 3'd0));
    got = {busy, var_h, tipo_h};
    n_checks++;
    if (got !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", got, pk(2'd0, 3'd0));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      stim_q.push_back(NONE);
      exp_q.push_back(pk(2'd0, 3'd0));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_type_cycling;
    logic [5:0] got;
    logic [2:0] nxt;
    for (int p = 0; p < 6; p++) begin
      nxt = (exp_tipo == 3'd4) ? 3'd0 : exp_tipo + 3'd1;
      for (int k = 0; k < 4; k++) begin
        stim_q.push_back((k == 0) ? TIPO : NONE);
        exp_q.push_back(pk(2'd0, (k < 2) ? exp_tipo : nxt));
      end
      exp_tipo = nxt;
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL type_cycling cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_jump;
    logic [5:0] got;
    for (int k = 0; k < 17; k++) begin
      stim_q.push_back((k == 0) ? SALT : NONE);
      exp_q.push_back(pk((k >= 2 && k <= 13) ? 2'd1 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL jump cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_fly;
    logic [5:0] got;
    for (int k = 0; k < 25; k++) begin
      stim_q.push_back((k == 0) ? VOLA : NONE);
      exp_q.push_back(pk((k >= 2 && k <= 21) ? 2'd2 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL fly cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_ignored_inputs;
    logic [5:0] got;
    logic [3:0] b;
    for (int k = 0; k < 31; k++) begin
      b = NONE;
      if (k == 0) b = SALT;
      if (k == 4) b = VOLA;
      if (k == 6) b = TIPO;
      stim_q.push_back(b);
      exp_q.push_back(pk((k >= 2 && k <= 13) ? 2'd1 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL ignored_inputs cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_simultaneous;
    logic [5:0] got;
    for (int k = 0; k < 17; k++) begin
      stim_q.push_back((k == 0) ? (SALT | VOLA) : NONE);
      exp_q.push_back(pk((k >= 2 && k <= 13) ? 2'd1 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL simultaneous cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_crouch;
    logic [5:0] got;
    for (int k = 0; k < 35; k++) begin
      stim_q.push_back((k < 30) ? AGAC : NONE);
      exp_q.push_back(pk((k >= 2 && k <= 31) ? 2'd3 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL crouch cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // Jump with btn_saltar held; fly requested so its edge lands on the first
  // IDLE cycle; the still-held jump button must not retrigger afterwards.
  task automatic test_back_to_back;
    logic [5:0] got;
    logic [3:0] b;
    logic [1:0] v;
    for (int k = 0; k < 45; k++) begin
      b = (k < 40) ? SALT : NONE;
      if (k == 13) b = b | VOLA;
      v = 2'd0;
      if (k >= 2 && k <= 13) v = 2'd1;
      if (k >= 15 && k <= 34) v = 2'd2;
      stim_q.push_back(b);
      exp_q.push_back(pk(v, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  // Reset asserted between clock edges in the middle of a fly.
  task automatic test_reset_mid_flight;
    logic [5:0] got;
    for (int k = 0; k < 6; k++) begin
      stim_q.push_back((k == 0) ? VOLA : NONE);
      exp_q.push_back(pk((k >= 2) ? 2'd2 : 2'd0, exp_tipo));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL mid_flight_pre cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    #2;
    rst_n = 1'b0;
    exp_tipo = 3'd0;
    #1;
    exp_q.push_back(pk(2'd0, 3'd0));
    got = {busy, var_h, tipo_h};
    n_checks++;
    if (got !== exp_q[0]) begin
      n_fail++;
      $display("FAIL mid_flight_async: got %b expected %b", got, exp_q[0]);
    end
    void'(exp_q.pop_front());
    for (int k = 0; k < 6; k++) begin
      stim_q.push_back(NONE);
      exp_q.push_back(pk(2'd0, 3'd0));
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      drive(stim_q.pop_front());
      if (k == 0) rst_n = 1'b1;
      got = {busy, var_h, tipo_h};
      n_checks++;
      if (got !== exp_q[0]) begin
        n_fail++;
        $display("FAIL mid_flight_post cyc %0d: got %b expected %b", k, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_type_cycling();
    test_jump();
    test_fly();
    test_ignored_inputs();
    test_simultaneous();
    test_crouch();
    test_back_to_back();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
